// File: rtl/sub_bytes_iter.sv
// Iterative AES SubBytes: substitutes NSBOX bytes of the 128-bit state per clock
// through combinational sbox lookups, then offers the result on a valid/ready port.

module sub_bytes_iter_sbox (
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);
    localparam logic [7:0] SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    assign out_byte = SBOX_TABLE[in_byte];
endmodule

module sub_bytes_iter #(
    parameter int NSBOX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);
    localparam int NGROUP = 16 / NSBOX;
    localparam int LAST   = NGROUP - 1;
    localparam int CNT_W  = (NGROUP > 1) ? $clog2(NGROUP) : 1;

    if (!(NSBOX == 1 || NSBOX == 2 || NSBOX == 4 || NSBOX == 8 || NSBOX == 16)) begin : g_bad_nsbox
        $error("sub_bytes_iter: NSBOX must be 1, 2, 4, 8 or 16");
    end

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [127:0]     state_q, state_d;

    logic [3:0] grp_idx [NSBOX];
    logic [7:0] sb_in   [NSBOX];
    logic [7:0] sb_out  [NSBOX];

    // Group cnt covers bytes cnt*NSBOX .. cnt*NSBOX+NSBOX-1.
    for (genvar gi = 0; gi < NSBOX; gi++) begin : g_sbox
        assign grp_idx[gi] = 4'(32'(cnt_q) * 32'(NSBOX) + 32'(gi));
        assign sb_in[gi]   = state_q[{grp_idx[gi], 3'b000} +: 8];

        sub_bytes_iter_sbox u_sbox (
            .in_byte  (sb_in[gi]),
            .out_byte (sb_out[gi])
        );
    end

    always_comb begin
        fsm_d   = fsm_q;
        cnt_d   = cnt_q;
        state_d = state_q;
        case (fsm_q)
            S_IDLE: begin
                if (in_valid) begin
                    state_d = in_state;
                    cnt_d   = '0;
                    fsm_d   = S_BUSY;
                end
            end
            S_BUSY: begin
                for (int j = 0; j < NSBOX; j++) begin
                    state_d[{grp_idx[j], 3'b000} +: 8] = sb_out[j];
                end
                if (cnt_q == CNT_W'(LAST)) begin
                    fsm_d = S_DONE;
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    fsm_d = S_IDLE;
                end
            end
            default: begin
                fsm_d = S_IDLE;
                cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= S_IDLE;
            cnt_q   <= '0;
            state_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    // Handshake flags decode straight from the state so reset clears them at once.
    assign in_ready  = (fsm_q == S_IDLE);
    assign out_valid = (fsm_q == S_DONE);
    assign busy      = (fsm_q != S_IDLE);
    assign out_state = state_q;
endmodule

// File: tb/tb_sub_bytes_iter.sv
// Scoreboard bench for sub_bytes_iter: GF(2^8) reference model, directed and random
// stimulus on an NSBOX=4 instance, plus a latency sweep over the other widths.

module tb_sub_bytes_iter;
    localparam logic [127:0] ALL63 = 128'h63636363636363636363636363636363;
    localparam logic [127:0] VEC2  = 128'h0f0e0d0c0b0a09080706050403020100;
    localparam logic [127:0] EXP2  = 128'h76abd7fe2b670130c56f6bf27b777c63;
    localparam logic [127:0] VEC3  = 128'hffffffffffffffffffffffffffffff53;
    localparam logic [127:0] EXP3  = 128'h161616161616161616161616161616ed;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, out_valid, out_ready, busy;
    logic [127:0] in_state, out_state;

    int n_cmp = 0;
    int n_bad = 0;
    int n_got = 0;
    int sweep_done = 0;
    logic sweep_go = 1'b0;
    logic rand_ready = 1'b0;

    logic [127:0] exp_q[$];
    logic [127:0] mon_exp;
    logic [7:0]   sbox_ref [256];

    always #5 clk = ~clk;

    sub_bytes_iter #(.NSBOX(4)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_state  (in_state),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_state (out_state),
        .busy      (busy)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
            y = {1'b0, y[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int k);
        logic [15:0] t = {b, b} << k;
        return t[15:8];
    endfunction

    function automatic logic [127:0] ref_state(input logic [127:0] s);
        logic [127:0] r = '0;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_ref[s[8*i +: 8]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: the handshake completes at the next rising edge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_output: got %h expected none", out_state);
            end else begin
                mon_exp = exp_q.pop_front();
                chk("scoreboard", out_state, mon_exp);
                n_got++;
            end
        end
    end

    always @(posedge clk) begin
        if (rand_ready) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    task automatic send(input logic [127:0] s, input logic [127:0] e);
        int w = 0;
        in_state = s;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && w < 300) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) begin
            chk("accept_timeout", 128'(in_ready), 128'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(posedge clk);
            #1 lat++;
        end while (!out_valid && lat < 60);
    endtask

    task automatic drain(input string name);
        int w = 0;
        while ((exp_q.size() != 0 || !in_ready) && w < 3000) begin
            @(posedge clk);
            #1 w++;
        end
        chk(name, 128'(exp_q.size()), 128'd0);
    endtask

    // Latency sweep over the remaining NSBOX widths, same vector each.
    for (genvar gi = 0; gi < 4; gi++) begin : g_sweep
        localparam int NS = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 8 : 16;
        logic         sv, sr, so_v, sor, sb;
        logic [127:0] ss, so;

        sub_bytes_iter #(.NSBOX(NS)) u_sw (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (sv),
            .in_ready  (sr),
            .in_state  (ss),
            .out_valid (so_v),
            .out_ready (sor),
            .out_state (so),
            .busy      (sb)
        );

        initial begin
            int lat;
            sv  = 1'b0;
            ss  = '0;
            sor = 1'b1;
            wait (sweep_go);
            @(posedge clk);
            #1;
            chk($sformatf("sweep%0d_ready", NS), 128'(sr), 128'd1);
            sv = 1'b1;
            ss = VEC2;
            @(posedge clk);
            #1 sv = 1'b0;
            lat = 0;
            while (!so_v && lat < 40) begin
                @(posedge clk);
                #1 lat++;
            end
            chk($sformatf("sweep%0d_latency", NS), 128'(lat), 128'(16 / NS));
            chk($sformatf("sweep%0d_state", NS), so, ref_state(VEC2));
            sweep_done++;
        end
    end

    initial begin
        int lat;
        int got0;
        int w;
        logic [127:0] s;
        logic [7:0] inv;

        for (int a = 0; a < 256; a++) begin
            inv = 8'h00;
            for (int b = 1; b < 256; b++) begin
                if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
            end
            sbox_ref[a] = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
        end

        rst = 1'b1;
        in_valid = 1'b0;
        in_state = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_in_ready", 128'(in_ready), 128'd1);
        chk("reset_out_valid", 128'(out_valid), 128'd0);
        chk("reset_busy", 128'(busy), 128'd0);
        chk("reset_out_state", out_state, 128'd0);
        rst = 1'b0;

        // All-zero state, latency and return to IDLE.
        out_ready = 1'b1;
        send(128'd0, ALL63);
        wait_valid(lat);
        chk("zero_latency", 128'(lat), 128'd4);
        chk("done_in_ready", 128'(in_ready), 128'd0);
        chk("done_busy", 128'(busy), 128'd1);
        @(posedge clk);
        #1;
        chk("post_hs_in_ready", 128'(in_ready), 128'd1);
        chk("post_hs_out_valid", 128'(out_valid), 128'd0);
        chk("post_hs_busy", 128'(busy), 128'd0);

        send(VEC2, EXP2);
        send(VEC3, EXP3);
        drain("directed_drain");

        // Backpressure with a noisy input port.
        out_ready = 1'b0;
        send(VEC2, EXP2);
        wait_valid(lat);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = ~in_valid;
            in_state = {$urandom, $urandom, $urandom, $urandom};
            chk("bp_out_valid", 128'(out_valid), 128'd1);
            chk("bp_out_state", out_state, EXP2);
            chk("bp_in_ready", 128'(in_ready), 128'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("bp_release_out_valid", 128'(out_valid), 128'd0);
        chk("bp_release_in_ready", 128'(in_ready), 128'd1);
        chk("bp_single_handshake", 128'(exp_q.size()), 128'd0);
        @(posedge clk);
        #1;
        chk("bp_no_reload", 128'(busy), 128'd0);

        // Asynchronous reset while cnt == 2.
        s = {$urandom, $urandom, $urandom, $urandom};
        send(s, ref_state(s));
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("midop_busy", 128'(busy), 128'd1);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_out_valid", 128'(out_valid), 128'd0);
        chk("async_rst_in_ready", 128'(in_ready), 128'd1);
        chk("async_rst_busy", 128'(busy), 128'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        send(128'd0, ALL63);
        wait_valid(lat);
        chk("after_rst_latency", 128'(lat), 128'd4);
        drain("after_rst_drain");

        // Random traffic with random gaps and backpressure.
        got0 = n_got;
        rand_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk);
                #1;
            end
            s = {$urandom, $urandom, $urandom, $urandom};
            send(s, ref_state(s));
        end
        drain("random_drain");
        chk("random_count", 128'(n_got - got0), 128'd100);
        rand_ready = 1'b0;
        @(posedge clk);
        #2 out_ready = 1'b1;

        sweep_go = 1'b1;
        w = 0;
        while (sweep_done < 4 && w < 200) begin
            @(posedge clk);
            #1 w++;
        end
        chk("sweep_complete", 128'(sweep_done), 128'd4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
